// File: rtl/hms_clock_set_if.sv
// rtl/hms_clock_set_if.sv - button/alarm inputs and time/status outputs of the hms clock
interface hms_clock_set_if #(
    parameter int CNT_W = 6
);
    logic             mode_pb;
    logic             incr_pb;
    logic             decr_pb;
    logic             alarm_en;
    logic [CNT_W-1:0] alarm_min;
    logic [CNT_W-1:0] alarm_hour;
    logic [CNT_W-1:0] sec_binary;
    logic [CNT_W-1:0] min_binary;
    logic [CNT_W-1:0] hour_binary;
    logic [1:0]       set_state;
    logic             alarm_out;
    logic             day_tick;

    modport master (
        output mode_pb, incr_pb, decr_pb, alarm_en, alarm_min, alarm_hour,
        input  sec_binary, min_binary, hour_binary, set_state, alarm_out, day_tick
    );

    modport slave (
        input  mode_pb, incr_pb, decr_pb, alarm_en, alarm_min, alarm_hour,
        output sec_binary, min_binary, hour_binary, set_state, alarm_out, day_tick
    );
endinterface

// File: rtl/hms_clock_set.sv
// rtl/hms_clock_set.sv - h:m:s time-of-day counter with set-mode FSM, daily alarm and day tick
module hms_clock_set #(
    parameter int SEC_MOD   = 60,
    parameter int MIN_MOD   = 60,
    parameter int HOUR_MOD  = 24,
    parameter int CNT_W     = 6,
    parameter int ALARM_LEN = 30
) (
    input logic          clk_1H,
    input logic          reset,
    hms_clock_set_if.slave bus
);
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_MIN  = 2'b01;
    localparam logic [1:0] ST_SET_HOUR = 2'b10;

    localparam logic [CNT_W-1:0] SEC_LAST  = CNT_W'(SEC_MOD - 1);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_MOD - 1);
    localparam logic [CNT_W-1:0] HOUR_LAST = CNT_W'(HOUR_MOD - 1);

    localparam int AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_LEN - 1);

    logic [CNT_W-1:0] sec_q, min_q, hour_q;
    logic [1:0]       state_q;
    logic             mode_pb_q;
    logic             day_q;
    logic             alarm_q;
    logic [AW-1:0]    alarm_cnt_q;

    logic mode_rise, adj_up, adj_dn;
    logic sec_wrap, min_wrap, hour_wrap;
    logic alarm_clear, alarm_match;

    assign mode_rise = bus.mode_pb & ~mode_pb_q;
    // Both buttons together cancel out rather than picking a winner.
    assign adj_up    = bus.incr_pb & ~bus.decr_pb;
    assign adj_dn    = bus.decr_pb & ~bus.incr_pb;
    assign sec_wrap  = (sec_q == SEC_LAST);
    assign min_wrap  = (min_q == MIN_LAST);
    assign hour_wrap = (hour_q == HOUR_LAST);

    assign alarm_clear = ~bus.alarm_en | bus.incr_pb | bus.decr_pb | bus.mode_pb;
    assign alarm_match = bus.alarm_en && (state_q == ST_RUN) &&
                         (hour_q == bus.alarm_hour) && (min_q == bus.alarm_min) &&
                         (sec_q == '0);

    function automatic logic [CNT_W-1:0] step_field(input logic [CNT_W-1:0] v,
                                                    input logic [CNT_W-1:0] last,
                                                    input logic             up);
        if (up)
            return (v == last) ? '0 : v + CNT_W'(1);
        else
            return (v == '0) ? last : v - CNT_W'(1);
    endfunction

    always_ff @(posedge clk_1H or posedge reset) begin
        if (reset) begin
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            state_q   <= ST_RUN;
            mode_pb_q <= 1'b0;
            day_q     <= 1'b0;
        end else begin
            mode_pb_q <= bus.mode_pb;
            day_q     <= 1'b0;
            // A mode edge only moves the FSM; no field moves on that edge.
            if (mode_rise) begin
                case (state_q)
                    ST_RUN: begin
                        state_q <= ST_SET_MIN;
                        sec_q   <= '0;
                    end
                    ST_SET_MIN: state_q <= ST_SET_HOUR;
                    default:    state_q <= ST_RUN;
                endcase
            end else begin
                case (state_q)
                    ST_RUN: begin
                        sec_q <= sec_wrap ? '0 : sec_q + CNT_W'(1);
                        if (sec_wrap) begin
                            min_q <= min_wrap ? '0 : min_q + CNT_W'(1);
                            if (min_wrap) begin
                                hour_q <= hour_wrap ? '0 : hour_q + CNT_W'(1);
                                day_q  <= hour_wrap;
                            end
                        end
                    end
                    ST_SET_MIN: begin
                        if (adj_up | adj_dn)
                            min_q <= step_field(min_q, MIN_LAST, adj_up);
                    end
                    ST_SET_HOUR: begin
                        if (adj_up | adj_dn)
                            hour_q <= step_field(hour_q, HOUR_LAST, adj_up);
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

    // Counter loads LEN-1 and the output drops one edge after it hits zero.
    always_ff @(posedge clk_1H or posedge reset) begin
        if (reset) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else if (alarm_clear) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else if (alarm_match) begin
            alarm_q     <= 1'b1;
            alarm_cnt_q <= ALARM_LOAD;
        end else if (alarm_q) begin
            if (alarm_cnt_q == '0)
                alarm_q <= 1'b0;
            else
                alarm_cnt_q <= alarm_cnt_q - AW'(1);
        end
    end

    assign bus.sec_binary  = sec_q;
    assign bus.min_binary  = min_q;
    assign bus.hour_binary = hour_q;
    assign bus.set_state   = state_q;
    assign bus.alarm_out   = alarm_q;
    assign bus.day_tick    = day_q;
endmodule
